entity_scanner: RTL and testbench

- Read-side initiator for the entity register file, and the feeder for the sprite engine.
- On each frame start it walks entity slots 0..STOP_ADDRESS-1, driving ADDRESS/RE into the entity file and capturing the returned SPRITE_ID/TARGET_X/TARGET_Y.
- Each captured entity goes to the sprite drawer over a valid/ready handshake. The scanner then waits for the drawer's completion pulse before fetching the next slot.

---
 rtl/entity_pkg.sv | 28 ++
 rtl/entity_scanner.sv | 123 ++++++++++++
 tb/tb_entity_scanner.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/entity_pkg.sv
// Shared types and sizing for the entity file read path and the sprite feeder.
package entity_pkg;

  localparam int ENTITY_SLOTS = 4;
  localparam int ADDR_W       = 2;
  localparam int ID_W         = 2;
  localparam int POS_W        = 9;
  localparam int IDX_W        = 3;

  // Field order matches the 20-bit entity-file word: id in the top bits, then x, then y.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } entity_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    WAIT_DONE
  } scan_state_t;

  function automatic logic [IDX_W-1:0] clamp_limit(input logic [IDX_W-1:0] stop);
    return (stop > IDX_W'(ENTITY_SLOTS)) ? IDX_W'(ENTITY_SLOTS) : stop;
  endfunction

endpackage

// File: rtl/entity_scanner.sv
// Walks the entity file once per frame and feeds each entity to the sprite drawer,
// waiting for the drawer to finish one sprite before fetching the next.
//
// state     | meaning
// IDLE      | waiting for FRAME_START
// FETCH     | RE high for one cycle, read data captured at the end of it
// PRESENT   | DRAW_VALID high until DRAW_READY is seen on an edge
// WAIT_DONE | drawer busy; DRAW_DONE advances to the next slot or ends the frame
module entity_scanner
  import entity_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              RESET_H,
  input  logic              FRAME_START,
  input  logic [IDX_W-1:0]  STOP_ADDRESS,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              RE,
  input  logic [ID_W-1:0]   SPRITE_ID,
  input  logic [POS_W-1:0]  TARGET_X,
  input  logic [POS_W-1:0]  TARGET_Y,
  output logic              DRAW_VALID,
  input  logic              DRAW_READY,
  output logic [ID_W-1:0]   DRAW_SPRITE_ID,
  output logic [POS_W-1:0]  DRAW_X,
  output logic [POS_W-1:0]  DRAW_Y,
  input  logic              DRAW_DONE,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              OVERRUN
);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] limit_q, limit_d;
  entity_t          draw_q, draw_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic [IDX_W-1:0] start_limit;
  logic [IDX_W-1:0] idx_next;

  assign start_limit = clamp_limit(STOP_ADDRESS);
  assign idx_next    = idx_q + IDX_W'(1);

  always_ff @(posedge CLOCK_50) begin
    if (RESET_H) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      limit_q      <= '0;
      draw_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      limit_q      <= limit_d;
      draw_q       <= draw_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    limit_d      = limit_q;
    draw_d       = draw_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    // A new frame request while scanning is dropped but remembered until reset.
    if (FRAME_START && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          limit_d = start_limit;
          if (start_limit == '0) begin
            frame_done_d = 1'b1;
          end else begin
            idx_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        draw_d.id = SPRITE_ID;
        draw_d.x  = TARGET_X;
        draw_d.y  = TARGET_Y;
        state_d   = PRESENT;
      end
      PRESENT: begin
        if (DRAW_READY) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (DRAW_DONE) begin
          if (idx_next == limit_q) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d   = idx_next;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ADDRESS        = idx_q[ADDR_W-1:0];
  assign RE             = (state_q == FETCH);
  assign DRAW_VALID     = (state_q == PRESENT);
  assign BUSY           = (state_q != IDLE);
  assign DRAW_SPRITE_ID = draw_q.id;
  assign DRAW_X         = draw_q.x;
  assign DRAW_Y         = draw_q.y;
  assign FRAME_DONE     = frame_done_q;
  assign OVERRUN        = overrun_q;

endmodule

// File: tb/tb_entity_scanner.sv
// Bench for entity_scanner: behavioural entity file and drawer, transfer scoreboard,
// a table of frame lengths, then hand-written stall/overrun/write/reset sequences.
module tb_entity_scanner;
  import entity_pkg::*;

  logic              CLOCK_50 = 1'b0;
  logic              RESET_H = 1'b1;
  logic              FRAME_START = 1'b0;
  logic [IDX_W-1:0]  STOP_ADDRESS = 3'd4;
  logic [ADDR_W-1:0] ADDRESS;
  logic              RE;
  logic [ID_W-1:0]   SPRITE_ID;
  logic [POS_W-1:0]  TARGET_X;
  logic [POS_W-1:0]  TARGET_Y;
  logic              DRAW_VALID;
  logic              DRAW_READY = 1'b1;
  logic [ID_W-1:0]   DRAW_SPRITE_ID;
  logic [POS_W-1:0]  DRAW_X;
  logic [POS_W-1:0]  DRAW_Y;
  logic              DRAW_DONE = 1'b0;
  logic              BUSY;
  logic              FRAME_DONE;
  logic              OVERRUN;

  entity_scanner dut (
    .CLOCK_50(CLOCK_50), .RESET_H(RESET_H), .FRAME_START(FRAME_START),
    .STOP_ADDRESS(STOP_ADDRESS), .ADDRESS(ADDRESS), .RE(RE),
    .SPRITE_ID(SPRITE_ID), .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y),
    .DRAW_VALID(DRAW_VALID), .DRAW_READY(DRAW_READY),
    .DRAW_SPRITE_ID(DRAW_SPRITE_ID), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y),
    .DRAW_DONE(DRAW_DONE), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  // Entity file model: read data only while RE is asserted.
  entity_t mem [ENTITY_SLOTS];
  entity_t golden [ENTITY_SLOTS];
  entity_t rd;
  assign rd        = RE ? mem[ADDRESS] : '0;
  assign SPRITE_ID = rd.id;
  assign TARGET_X  = rd.x;
  assign TARGET_Y  = rd.y;

  int tests_run = 0;
  int tests_failed = 0;
  int fetch_cnt = 0;
  int xfer_cnt = 0;
  int fd_cnt = 0;
  int exp_addr = 0;
  entity_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard / monitor
  initial begin
    entity_t e;
    forever begin
      @(negedge CLOCK_50);
      if (!RESET_H) begin
        if (FRAME_DONE) fd_cnt++;
        if (RE) begin
          chk("fetch_addr", 32'(ADDRESS), exp_addr);
          exp_addr++;
          fetch_cnt++;
        end
        if (DRAW_VALID && DRAW_READY) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            chk("xfer_unexpected", 32'(xfer_cnt), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_entity", 32'({DRAW_SPRITE_ID, DRAW_X, DRAW_Y}), 32'(e));
          end
        end
      end
    end
  end

  // Drawer: DRAW_DONE pulse two cycles after each accepted transfer.
  initial begin
    int  done_cnt;
    logic acc;
    done_cnt = 0;
    forever begin
      @(negedge CLOCK_50);
      acc = DRAW_VALID && DRAW_READY && !RESET_H;
      @(posedge CLOCK_50);
      #1;
      DRAW_DONE = 1'b0;
      if (acc) begin
        done_cnt = 2;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) DRAW_DONE = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(golden[i]);
  endtask

  task automatic clr_counts();
    fetch_cnt = 0;
    xfer_cnt  = 0;
    fd_cnt    = 0;
    exp_addr  = 0;
  endtask

  task automatic pulse_fs();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (!BUSY) return;
    end
    chk(name, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_re_addr(input int a);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (RE && (ADDRESS == ADDR_W'(a))) return;
    end
    chk("wait_re_timeout", 32'(a), 32'hFFFF);
  endtask

  task automatic wait_accept(input int a);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (DRAW_VALID && DRAW_READY && (ADDRESS == ADDR_W'(a))) return;
    end
    chk("wait_accept_timeout", 32'(a), 32'hFFFF);
  endtask

  typedef struct {
    logic [IDX_W-1:0] stop;
    int               n_fetch;
  } vec_t;

  vec_t vec [6];

  initial begin
    int fd0;
    golden[0] = '{id: 2'd0, x: 9'd32,  y: 9'd32};
    golden[1] = '{id: 2'd1, x: 9'd256, y: 9'd32};
    golden[2] = '{id: 2'd1, x: 9'd32,  y: 9'd192};
    golden[3] = '{id: 2'd2, x: 9'd256, y: 9'd192};
    for (int i = 0; i < ENTITY_SLOTS; i++) mem[i] = golden[i];
    vec[0] = '{stop: 3'd4, n_fetch: 4};
    vec[1] = '{stop: 3'd0, n_fetch: 0};
    vec[2] = '{stop: 3'd7, n_fetch: 4};
    vec[3] = '{stop: 3'd1, n_fetch: 1};
    vec[4] = '{stop: 3'd3, n_fetch: 3};
    vec[5] = '{stop: 3'd5, n_fetch: 4};

    RESET_H = 1'b1;
    repeat (3) tick();
    RESET_H = 1'b0;
    @(negedge CLOCK_50);
    chk("reset_outputs", 32'({ADDRESS, RE, DRAW_VALID, DRAW_SPRITE_ID, DRAW_X, DRAW_Y,
                              BUSY, FRAME_DONE, OVERRUN}), 32'd0);
    tick();

    for (int v = 0; v < 6; v++) begin
      STOP_ADDRESS = vec[v].stop;
      clr_counts();
      push_exp(vec[v].n_fetch);
      pulse_fs();
      @(negedge CLOCK_50);
      chk("lat_re_n1", 32'(RE), 32'(vec[v].n_fetch > 0));
      if (vec[v].n_fetch == 0) begin
        chk("lat_fd_n1", 32'(FRAME_DONE), 32'd1);
      end else begin
        @(negedge CLOCK_50);
        chk("lat_valid_n2", 32'(DRAW_VALID), 32'd1);
      end
      wait_idle("frame_timeout");
      repeat (3) @(negedge CLOCK_50);
      chk("fetch_count", 32'(fetch_cnt), 32'(vec[v].n_fetch));
      chk("xfer_count", 32'(xfer_cnt), 32'(vec[v].n_fetch));
      chk("frame_done_count", 32'(fd_cnt), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      tick();
    end

    // Drawer stalls slot 1 for five cycles.
    STOP_ADDRESS = 3'd4;
    clr_counts();
    push_exp(4);
    pulse_fs();
    wait_re_addr(1);
    tick();
    DRAW_READY = 1'b0;
    fd0 = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      chk("stall_valid", 32'(DRAW_VALID), 32'd1);
      chk("stall_x", 32'(DRAW_X), 32'd256);
      chk("stall_re", 32'(RE), 32'd0);
    end
    chk("stall_no_xfer", 32'(xfer_cnt), 32'(fd0));
    tick();
    DRAW_READY = 1'b1;
    wait_idle("stall_timeout");
    repeat (3) @(negedge CLOCK_50);
    chk("stall_xfer_count", 32'(xfer_cnt), 32'd4);
    chk("stall_fetch_count", 32'(fetch_cnt), 32'd4);
    tick();

    // FRAME_START during slot 2's WAIT_DONE.
    chk("overrun_clear", 32'(OVERRUN), 32'd0);
    clr_counts();
    push_exp(4);
    pulse_fs();
    wait_accept(2);
    tick();
    pulse_fs();
    @(negedge CLOCK_50);
    chk("overrun_set", 32'(OVERRUN), 32'd1);
    wait_idle("overrun_timeout");
    repeat (3) @(negedge CLOCK_50);
    chk("overrun_xfer_count", 32'(xfer_cnt), 32'd4);
    chk("overrun_fetch_count", 32'(fetch_cnt), 32'd4);
    chk("overrun_fd_count", 32'(fd_cnt), 32'd1);
    tick();

    // Slot 3 rewritten while slot 1 is being drawn.
    clr_counts();
    push_exp(3);
    exp_q.push_back('{id: 2'd3, x: 9'd100, y: 9'd50});
    pulse_fs();
    wait_accept(1);
    mem[3] = '{id: 2'd3, x: 9'd100, y: 9'd50};
    wait_idle("write_timeout");
    repeat (3) @(negedge CLOCK_50);
    chk("write_xfer_count", 32'(xfer_cnt), 32'd4);
    chk("write_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("overrun_sticky", 32'(OVERRUN), 32'd1);
    mem[3] = golden[3];
    tick();

    // Reset during slot 2's PRESENT.
    clr_counts();
    push_exp(4);
    pulse_fs();
    wait_re_addr(2);
    tick();
    DRAW_READY = 1'b0;
    RESET_H    = 1'b1;
    fd0 = fd_cnt;
    tick();
    RESET_H = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_outputs", 32'({ADDRESS, RE, DRAW_VALID, DRAW_SPRITE_ID, DRAW_X, DRAW_Y,
                              BUSY, FRAME_DONE, OVERRUN}), 32'd0);
    repeat (5) @(negedge CLOCK_50);
    chk("abort_no_fd", 32'(fd_cnt), 32'(fd0));
    chk("abort_idle", 32'(BUSY), 32'd0);
    exp_q.delete();
    DRAW_READY = 1'b1;
    tick();
    clr_counts();
    push_exp(4);
    pulse_fs();
    @(negedge CLOCK_50);
    chk("restart_addr0", 32'({RE, ADDRESS}), 32'({1'b1, 2'd0}));
    wait_idle("restart_timeout");
    repeat (3) @(negedge CLOCK_50);
    chk("restart_xfer_count", 32'(xfer_cnt), 32'd4);
    chk("restart_fd_count", 32'(fd_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
